// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store and memory-side signals of the shared memory port.
// The arbiter connects through the master modport and the environment through the slave modport.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_valid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [2:0]    d_access;
  logic          d_gnt;
  logic          d_valid;
  logic          d_err;
  logic [DW-1:0] d_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_access;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_access, mem_ack, mem_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_err, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_access
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_access, mem_ack, mem_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_err, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_access
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time,
// with fetch-starvation protection and data-access misalignment checking.
//
// state   | meaning
// IDLE    | no transaction; arbitrate pending requests
// BUSY_IF | fetch transaction on the memory port, waiting for mem_ack
// BUSY_D  | data transaction on the memory port, waiting for mem_ack
// ERR_D   | misaligned data access; report error next cycle without touching memory
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, ERR_D} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t        state_q, state_d;
  logic [3:0]    starve_q, starve_d;
  logic          if_gnt_q, if_gnt_d;
  logic          if_valid_q, if_valid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic          d_gnt_q, d_gnt_d;
  logic          d_valid_q, d_valid_d;
  logic          d_err_q, d_err_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]    mem_access_q, mem_access_d;
  logic          misaligned;
  logic          force_fetch;

  // Reserved funct3 codes are reported as errors alongside true misalignment.
  always_comb begin
    case (bus.d_access)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = bus.d_addr[0];
      3'b010:         misaligned = |bus.d_addr[1:0];
      default:        misaligned = 1'b1;
    endcase
  end

  assign force_fetch = bus.if_req && (starve_q == LIMIT);

  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    if_gnt_d     = 1'b0;
    if_valid_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_gnt_d      = 1'b0;
    d_valid_d    = 1'b0;
    d_err_d      = 1'b0;
    d_rdata_d    = d_rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_access_d = mem_access_q;

    case (state_q)
      IDLE: begin
        if (!bus.if_req) starve_d = '0;
        if (bus.d_req && !force_fetch) begin
          d_gnt_d      = 1'b1;
          mem_we_d     = bus.d_we;
          mem_addr_d   = bus.d_addr;
          mem_wdata_d  = bus.d_wdata;
          mem_access_d = bus.d_access;
          if (bus.if_req) starve_d = starve_q + 4'd1;
          if (misaligned) begin
            state_d = ERR_D;
          end else begin
            state_d   = BUSY_D;
            mem_req_d = 1'b1;
          end
        end else if (bus.if_req) begin
          if_gnt_d     = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = bus.if_addr;
          mem_wdata_d  = '0;
          mem_access_d = 3'b010;
          starve_d     = '0;
          state_d      = BUSY_IF;
          mem_req_d    = 1'b1;
        end
      end
      BUSY_IF: begin
        if (bus.mem_ack) begin
          if_rdata_d = bus.mem_rdata;
          if_valid_d = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = IDLE;
        end
      end
      BUSY_D: begin
        if (bus.mem_ack) begin
          if (!mem_we_q) d_rdata_d = bus.mem_rdata;
          d_valid_d = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      ERR_D: begin
        d_valid_d = 1'b1;
        d_err_d   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      if_gnt_q     <= 1'b0;
      if_valid_q   <= 1'b0;
      if_rdata_q   <= '0;
      d_gnt_q      <= 1'b0;
      d_valid_q    <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_access_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      if_gnt_q     <= if_gnt_d;
      if_valid_q   <= if_valid_d;
      if_rdata_q   <= if_rdata_d;
      d_gnt_q      <= d_gnt_d;
      d_valid_q    <= d_valid_d;
      d_err_q      <= d_err_d;
      d_rdata_q    <= d_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_access_q <= mem_access_d;
    end
  end

  assign bus.if_gnt     = if_gnt_q;
  assign bus.if_valid   = if_valid_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.d_gnt      = d_gnt_q;
  assign bus.d_valid    = d_valid_q;
  assign bus.d_err      = d_err_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_access = mem_access_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, data, arbitration, starvation, misalignment and reset.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   d_gnts;
  int   i_gnts;
  int   guard;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.if_req = 0; bus.if_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_access = 0;
    bus.mem_ack = 0; bus.mem_rdata = 0;

    #12;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_gnts", {bus.if_gnt, bus.d_gnt}, 0);
    chk("rst_valids", {bus.if_valid, bus.d_valid, bus.d_err}, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    rst_n = 1'b1;
    tick();

    // fetch alone, ack in first mem_req cycle
    bus.if_req = 1; bus.if_addr = 32'h100; bus.mem_ack = 1; bus.mem_rdata = 32'h0050_0093;
    tick();
    chk("f_if_gnt", bus.if_gnt, 1);
    chk("f_mem_req", bus.mem_req, 1);
    chk("f_mem_addr", bus.mem_addr, 32'h100);
    chk("f_mem_access", bus.mem_access, 3'b010);
    bus.if_req = 0;
    tick();
    chk("f_if_valid", bus.if_valid, 1);
    chk("f_if_rdata", bus.if_rdata, 32'h0050_0093);
    chk("f_mem_req_off", bus.mem_req, 0);
    bus.mem_ack = 0;
    tick();
    chk("f_if_valid_pulse", bus.if_valid, 0);

    // simultaneous requests, data wins, ack delayed 2 cycles
    bus.if_req = 1; bus.if_addr = 32'h104;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200; bus.d_access = 3'b010;
    tick();
    chk("s_gnts", {bus.if_gnt, bus.d_gnt}, 2'b01);
    chk("s_addr1", bus.mem_addr, 32'h200);
    bus.d_req = 0;
    tick();
    chk("s_addr2", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h200});
    tick();
    chk("s_addr3", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h200});
    bus.mem_ack = 1; bus.mem_rdata = 32'h1122_3344;
    tick();
    chk("s_d_valid", {bus.d_valid, bus.d_err, bus.mem_req}, 3'b100);
    chk("s_d_rdata", bus.d_rdata, 32'h1122_3344);
    bus.mem_rdata = 32'h0000_0013;
    tick();
    chk("s_if_gnt", {bus.if_gnt, bus.d_gnt}, 2'b10);
    chk("s_if_addr", {bus.mem_addr, bus.mem_access}, {32'h104, 3'b010});
    bus.if_req = 0;
    tick();
    chk("s_if_valid", {bus.if_valid, bus.if_rdata}, {1'b1, 32'h0000_0013});
    bus.mem_ack = 0;
    tick();

    // starvation: both held high, ack always present
    bus.if_req = 1; bus.if_addr = 32'h108;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300; bus.d_access = 3'b010;
    bus.mem_ack = 1; bus.mem_rdata = 32'hA5;
    d_gnts = 0; i_gnts = 0; guard = 0;
    while (i_gnts == 0 && guard < 40) begin
      tick();
      guard++;
      if (bus.d_gnt) d_gnts++;
      if (bus.if_gnt) i_gnts++;
      if (bus.if_gnt && bus.d_gnt) chk("st_double_gnt", 1, 0);
    end
    bus.if_req = 0; bus.d_req = 0;
    chk("st_fetch_seen", i_gnts, 1);
    chk("st_data_grants", d_gnts, 4);
    chk("st_counter", dut.starve_q, 0);
    tick();
    chk("st_if_valid", {bus.if_valid, bus.if_rdata}, {1'b1, 32'hA5});
    bus.mem_ack = 0;
    tick();

    // misaligned word store
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h202; bus.d_wdata = 32'h55; bus.d_access = 3'b010;
    tick();
    chk("m_gnt", {bus.d_gnt, bus.mem_req}, 2'b10);
    bus.d_req = 0;
    tick();
    chk("m_err", {bus.d_valid, bus.d_err, bus.mem_req}, 3'b110);
    tick();
    chk("m_idle", {bus.d_valid, bus.d_err, bus.mem_req}, 3'b000);

    // reserved funct3 on aligned address also errors
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200; bus.d_access = 3'b011;
    tick();
    chk("r_gnt", {bus.d_gnt, bus.mem_req}, 2'b10);
    bus.d_req = 0;
    tick();
    chk("r_err", {bus.d_valid, bus.d_err}, 2'b11);
    tick();

    // halfword load at 0x202 is aligned
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h202; bus.d_access = 3'b001;
    bus.mem_ack = 1; bus.mem_rdata = 32'hBEEF;
    tick();
    chk("h_gnt", {bus.d_gnt, bus.mem_req, bus.mem_access}, {2'b11, 3'b001});
    bus.d_req = 0;
    tick();
    chk("h_valid", {bus.d_valid, bus.d_err}, 2'b10);
    chk("h_rdata", bus.d_rdata, 32'hBEEF);

    // store then load back-to-back
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h40; bus.d_wdata = 32'hDEAD_BEEF; bus.d_access = 3'b010;
    bus.mem_rdata = 32'h0BAD_0BAD;
    tick();
    chk("sl_store", {bus.d_gnt, bus.mem_we, bus.mem_wdata}, {2'b11, 32'hDEAD_BEEF});
    bus.d_req = 0;
    tick();
    chk("sl_store_done", {bus.d_valid, bus.d_err}, 2'b10);
    chk("sl_rdata_kept", bus.d_rdata, 32'hBEEF);
    bus.d_req = 1; bus.d_we = 0;
    tick();
    chk("sl_load", {bus.d_gnt, bus.mem_we, bus.mem_addr}, {2'b10, 32'h40});
    bus.d_req = 0; bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("sl_load_data", {bus.d_valid, bus.d_rdata}, {1'b1, 32'hDEAD_BEEF});
    bus.mem_ack = 0;
    tick();

    // reset in BUSY_D before ack
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h80; bus.d_access = 3'b010;
    tick();
    chk("rs_busy", {bus.d_gnt, bus.mem_req}, 2'b11);
    bus.d_req = 0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rs_mem_req", bus.mem_req, 0);
    chk("rs_outputs", {bus.mem_addr, bus.d_rdata, bus.if_rdata}, 0);
    #2;
    rst_n = 1'b1;
    bus.mem_ack = 1; bus.mem_rdata = 32'h7777;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rs_no_valid", {bus.d_valid, bus.if_valid, bus.mem_req, bus.d_gnt}, 0);
    end
    bus.mem_ack = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single memory port between the instruction-fetch requester and the load/store data requester of the RISC-V core. It latches each request, drives one memory transaction at a time with a req/ack handshake, and returns read data to the winning requester. It also checks data accesses for misalignment using the funct3-encoded access size.

Parameters:
AW, 32, address width
DW, 32, data width
STARVE_LIMIT, 4, consecutive data grants allowed while if_req is pending before fetch is forced to win (1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held high until if_gnt is seen
if_addr  in  AW  fetch address, word aligned
if_gnt  out  1  one-cycle pulse: fetch request latched
if_valid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DW  fetched instruction
d_req  in  1  data request; held high until d_gnt is seen
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_access  in  3  funct3 access size/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu)
d_gnt  out  1  one-cycle pulse: data request latched
d_valid  out  1  one-cycle pulse: data access complete (load data or store done)
d_err  out  1  qualified by d_valid: access was misaligned, memory not touched
d_rdata  out  DW  load data
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  write enable
mem_addr  out  AW  address
mem_wdata  out  DW  write data
mem_access  out  3  access size code, passed through from d_access; 010 for fetch
mem_ack  in  1  memory completion; may arrive in the first mem_req cycle or later
mem_rdata  in  DW  read data, valid with mem_ack

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output 0; starve counter 0. A reset mid-transaction drops mem_req immediately, and the transaction is abandoned with no valid pulse.
- States: IDLE, BUSY_IF, BUSY_D, ERR_D.
- IDLE arbitration, when any request is present:
  - Winner is data, unless if_req=1 and the starve counter equals STARVE_LIMIT; in that case the winner is fetch.
  - If only one request is present, that requester wins.
  - The winner's address, we, wdata and access are latched into output registers.
  - The winner's gnt pulses in the next cycle, which is the first cycle of BUSY_x.
- Data request misaligned (word with addr[1:0]!=0; halfword with addr[0]=1; d_access 011/110/111 is also treated as an error):
  - Next state is ERR_D, and d_gnt pulses.
  - The cycle after that: d_valid=1, d_err=1, mem_req stays 0, state returns to IDLE.
- BUSY_x:
  - mem_req=1 and the mem_* outputs are stable for the whole state.
  - On a cycle with mem_ack=1: mem_rdata is captured into x_rdata; in the next cycle x_valid=1, mem_req=0 and state is IDLE.
  - Minimum latency from req to valid is 3 cycles (IDLE accept, BUSY with ack, valid).
- Requester contract:
  - A requester deasserts req in the cycle after it sees gnt.
  - The arbiter ignores req while in BUSY_x or ERR_D.
  - New requests are arbitrated in the IDLE cycle that coincides with a valid pulse (back-to-back allowed).
- Store: d_rdata is left unchanged; d_valid pulses with d_err=0.
- x_rdata holds its value until the next completion for that requester.
- Starve counter:
  - Increments on each data grant while if_req=1, saturating at STARVE_LIMIT.
  - Clears on a fetch grant.
  - Clears when if_req=0 in IDLE.
- mem_ack received outside BUSY states is ignored.
- Never two gnts in one cycle; never more than one outstanding memory transaction.

Test Plan:
- Fetch alone: if_req=1, if_addr=0x100, mem_ack on the first mem_req cycle with mem_rdata=0x00500093 -> mem_req high for 1 cycle, mem_access=010; if_valid 3 cycles after req with if_rdata=0x00500093.
- Simultaneous if_req and d_req (load, 0x200, access 010), mem_ack delayed 2 cycles -> data granted first, mem_addr=0x200 stable 3 cycles; fetch granted in the IDLE cycle coinciding with d_valid.
- Starvation: d_req continuously re-asserted and if_req held high, STARVE_LIMIT=4 -> exactly 4 data grants, then if_gnt; counter reads 0 afterwards.
- Misaligned store: d_we=1, d_addr=0x202, d_access=010 -> d_gnt, then d_valid=1 with d_err=1; mem_req never asserted. Halfword at 0x202 -> proceeds normally.
- Reset mid-operation: rst_n low in BUSY_D before mem_ack -> mem_req and all outputs 0 immediately; after release, a late mem_ack is ignored and no d_valid pulse occurs.
- Store then load back-to-back: store 0xDEADBEEF to 0x40, then load from 0x40 -> mem_we=1 then 0; d_rdata=0xDEADBEEF; d_rdata unchanged after the store completion.
